// File: rtl/dino_game_sequencer.sv
// Game controller for the dino score/RNG datapath: score pacing, speed levels, RNG-scheduled spawns.
// Optional pause support is built when DINO_PAUSE_EN is defined.
module dino_game_sequencer #(
    parameter int SCORE_DIV  = 6,
    parameter int MIN_GAP    = 20,
    parameter int GAP_BITS   = 6,
    parameter int SPEED_STEP = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       start_btn,
    input  logic       pause_btn,
    input  logic       collision,
    input  logic       rng_valid,
    input  logic [7:0] rng_data,
    output logic       rng_req,
    output logic       score_clr,
    output logic       score_inc,
    output logic       spawn,
    output logic [1:0] speed,
    output logic [1:0] state,
    output logic       game_over
);

    localparam int FD_W  = $clog2(SCORE_DIV + 1);
    localparam int SD_W  = $clog2(SPEED_STEP + 1);
    localparam int GAP_W = $clog2(MIN_GAP + 2**GAP_BITS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_OVER  = 2'b11
    } state_t;

    state_t             state_q, state_d;
    logic [FD_W-1:0]    frame_div_q, frame_div_d;
    logic [SD_W-1:0]    score_div_q, score_div_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic               gap_loaded_q, gap_loaded_d;
    logic [1:0]         speed_q, speed_d;
    logic               rng_req_q, rng_req_d;
    logic               score_clr_q, score_clr_d;
    logic               score_inc_q, score_inc_d;
    logic               spawn_q, spawn_d;
    logic               game_over_q, game_over_d;
    logic               start_q;
    logic               start_rise_s;
    logic               xfer_s;
    logic               load_s;
    logic               restart_s;
    logic [GAP_BITS-1:0] rng_bits_s;
    logic [GAP_W-1:0]   gap_load_s;
    logic               unused_s;

`ifdef DINO_PAUSE_EN
    logic               pause_q;
    logic               pause_rise_s;
    assign pause_rise_s = pause_btn & ~pause_q;
    assign unused_s     = ^rng_data;
`else
    assign unused_s     = ^{pause_btn, rng_data};
`endif

    assign start_rise_s = start_btn & ~start_q;
    assign xfer_s       = rng_req_q & rng_valid;
    assign rng_bits_s   = rng_data[GAP_BITS-1:0] >> speed_q;
    assign gap_load_s   = GAP_W'(MIN_GAP) + GAP_W'(rng_bits_s);

    // Next-state logic: collision > pause > frame/RNG work in RUN; RNG load beats a same-cycle tick.
    always_comb begin
        state_d      = state_q;
        frame_div_d  = frame_div_q;
        score_div_d  = score_div_q;
        gap_cnt_d    = gap_cnt_q;
        gap_loaded_d = gap_loaded_q;
        speed_d      = speed_q;
        rng_req_d    = rng_req_q;
        score_clr_d  = 1'b0;
        score_inc_d  = 1'b0;
        spawn_d      = 1'b0;
        load_s       = 1'b0;
        restart_s    = 1'b0;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_rise_s) begin
                    restart_s = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                if (collision) begin
                    state_d   = ST_OVER;
                    rng_req_d = 1'b0;
`ifdef DINO_PAUSE_EN
                end else if (pause_rise_s) begin
                    state_d = ST_PAUSE;
                    load_s  = xfer_s;
`endif
                end else begin
                    if (frame_tick) begin
                        if (frame_div_q == FD_W'(SCORE_DIV - 1)) begin
                            frame_div_d = {FD_W{1'b0}};
                            score_inc_d = 1'b1;
                            if (score_div_q == SD_W'(SPEED_STEP - 1)) begin
                                score_div_d = {SD_W{1'b0}};
                                if (speed_q != 2'd3) begin
                                    speed_d = speed_q + 2'd1;
                                end else begin
                                    speed_d = speed_q;
                                end
                            end else begin
                                score_div_d = score_div_q + SD_W'(1);
                            end
                        end else begin
                            frame_div_d = frame_div_q + FD_W'(1);
                        end
                    end else begin
                        frame_div_d = frame_div_q;
                    end

                    if (xfer_s) begin
                        load_s = 1'b1;
                    end else if (frame_tick && gap_loaded_q) begin
                        if (gap_cnt_q == GAP_W'(1)) begin
                            gap_cnt_d    = {GAP_W{1'b0}};
                            gap_loaded_d = 1'b0;
                            spawn_d      = 1'b1;
                            rng_req_d    = 1'b1;
                        end else begin
                            gap_cnt_d = gap_cnt_q - GAP_W'(1);
                        end
                    end else begin
                        gap_cnt_d = gap_cnt_q;
                    end
                end
            end
            ST_PAUSE: begin
`ifdef DINO_PAUSE_EN
                load_s = xfer_s;
                if (start_rise_s) begin
                    restart_s = 1'b1;
                end else if (pause_rise_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = state_q;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load_s) begin
            gap_cnt_d    = gap_load_s;
            gap_loaded_d = 1'b1;
            rng_req_d    = 1'b0;
        end else begin
            gap_loaded_d = gap_loaded_d;
        end

        if (restart_s) begin
            state_d      = ST_RUN;
            score_clr_d  = 1'b1;
            speed_d      = 2'd0;
            frame_div_d  = {FD_W{1'b0}};
            score_div_d  = {SD_W{1'b0}};
            gap_cnt_d    = {GAP_W{1'b0}};
            gap_loaded_d = 1'b0;
            rng_req_d    = 1'b1;
        end else begin
            state_d = state_d;
        end

        game_over_d = (state_d == ST_OVER);
    end

    // State and output registers; button edge regs track the pins through reset so a held button cannot fire on release.
    always_ff @(posedge clk) begin
        start_q <= start_btn;
`ifdef DINO_PAUSE_EN
        pause_q <= pause_btn;
`endif
        if (rst) begin
            state_q      <= ST_IDLE;
            frame_div_q  <= {FD_W{1'b0}};
            score_div_q  <= {SD_W{1'b0}};
            gap_cnt_q    <= {GAP_W{1'b0}};
            gap_loaded_q <= 1'b0;
            speed_q      <= 2'd0;
            rng_req_q    <= 1'b0;
            score_clr_q  <= 1'b0;
            score_inc_q  <= 1'b0;
            spawn_q      <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_div_q  <= frame_div_d;
            score_div_q  <= score_div_d;
            gap_cnt_q    <= gap_cnt_d;
            gap_loaded_q <= gap_loaded_d;
            speed_q      <= speed_d;
            rng_req_q    <= rng_req_d;
            score_clr_q  <= score_clr_d;
            score_inc_q  <= score_inc_d;
            spawn_q      <= spawn_d;
            game_over_q  <= game_over_d;
        end
    end

    assign rng_req   = rng_req_q;
    assign score_clr = score_clr_q;
    assign score_inc = score_inc_q;
    assign spawn     = spawn_q;
    assign speed     = speed_q;
    assign state     = state_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_dino_game_sequencer.sv
// Self-checking bench for dino_game_sequencer (default parameters): vector table with scoreboard
// queue, then hand-written multi-cycle sequences for gap timing, RNG starvation and speed saturation.
module tb_dino_game_sequencer;

    logic       clk = 1'b0;
    logic       rst, frame_tick, start_btn, pause_btn, collision, rng_valid;
    logic [7:0] rng_data;
    logic       rng_req, score_clr, score_inc, spawn, game_over;
    logic [1:0] speed, state;

    int tests = 0;
    int fails = 0;
    int inc_cnt = 0;
    int spawn_cnt = 0;

    dino_game_sequencer dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .start_btn(start_btn),
        .pause_btn(pause_btn), .collision(collision), .rng_valid(rng_valid),
        .rng_data(rng_data), .rng_req(rng_req), .score_clr(score_clr),
        .score_inc(score_inc), .spawn(spawn), .speed(speed), .state(state),
        .game_over(game_over)
    );

    always #5 clk = ~clk;

    // {state, game_over, speed, rng_req, score_clr, score_inc, spawn}
    typedef struct {
        logic       r, s, p, c, t, v;
        logic [7:0] d;
        logic [8:0] exp;
    } vec_t;

    localparam logic [8:0] E_IDLE    = 9'b00_0_00_0000;
    localparam logic [8:0] E_RUN_CLR = 9'b01_0_00_1100;
    localparam logic [8:0] E_RUN_REQ = 9'b01_0_00_1000;
    localparam logic [8:0] E_RUN_INC = 9'b01_0_00_1010;
    localparam logic [8:0] E_RUN     = 9'b01_0_00_0000;
    localparam logic [8:0] E_OVER    = 9'b11_1_00_0000;

    vec_t       vecs[$];
    logic [8:0] exp_q[$];

    function automatic vec_t mk(input logic r, s, p, c, t, v, input logic [7:0] d, input logic [8:0] e);
        vec_t x;
        x.r = r; x.s = s; x.p = p; x.c = c; x.t = t; x.v = v; x.d = d; x.exp = e;
        return x;
    endfunction

    function automatic logic [8:0] outs();
        return {state, game_over, speed, rng_req, score_clr, score_inc, spawn};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, s, p, c, t, v, input logic [7:0] d);
        rst = r; start_btn = s; pause_btn = p; collision = c; frame_tick = t;
        rng_valid = v; rng_data = d;
        @(posedge clk);
        #1;
        inc_cnt   += int'(score_inc);
        spawn_cnt += int'(spawn);
    endtask

    task automatic tick_idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        int n;
        rst = 1'b1; start_btn = 1'b0; pause_btn = 1'b0; collision = 1'b0;
        frame_tick = 1'b0; rng_valid = 1'b0; rng_data = 8'h00;

        //                  r     s     p     c     t     v     data   expected
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, E_IDLE));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, E_IDLE));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, E_IDLE));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, E_IDLE));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, E_IDLE));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, E_RUN_CLR));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, E_RUN_REQ));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, E_RUN_REQ));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, E_RUN_INC));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, E_RUN_REQ));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h05, E_RUN));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, E_RUN));
        // frame_div is 5 here: collision must swallow the score tick
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, E_OVER));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, E_OVER));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, E_RUN_CLR));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, E_RUN_REQ));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, E_RUN_REQ));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, E_RUN_REQ));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, E_IDLE));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, E_IDLE));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, E_RUN_CLR));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, E_RUN_REQ));

        foreach (vecs[i]) begin
            exp_q.push_back(vecs[i].exp);
            step(vecs[i].r, vecs[i].s, vecs[i].p, vecs[i].c, vecs[i].t, vecs[i].v, vecs[i].d);
            check($sformatf("vec%0d", i), int'(outs()), int'(exp_q.pop_front()));
        end

        // Fresh RUN: 12 ticks give 2 score pulses, and no spawn without an RNG value
        inc_cnt = 0; spawn_cnt = 0;
        for (int i = 0; i < 12; i++) tick_idle();
        check("inc_12_ticks", inc_cnt, 2);
        check("no_spawn_unloaded", spawn_cnt, 0);
        check("req_waiting", int'(rng_req), 1);

        // Gap 20 + 5 = 25 frames at speed 0
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h05);
        check("req_drop", int'(rng_req), 0);
        spawn_cnt = 0;
        for (int i = 0; i < 24; i++) tick_idle();
        check("no_spawn_before_25", spawn_cnt, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        check("spawn_at_25", int'(spawn), 1);
        check("req_after_spawn", int'(rng_req), 1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        check("spawn_one_cycle", int'(spawn), 0);

        // Starve the RNG well beyond 50 frames while climbing to speed 2
        spawn_cnt = 0; n = 0;
        while (inc_cnt < 200 && n < 3000) begin tick_idle(); n++; end
        check("inc_reach_200", inc_cnt, 200);
        check("speed_2", int'(speed), 2);
        check("no_spawn_starved", spawn_cnt, 0);

        // Load with a same-cycle tick: 20 + (63 >> 2) = 35 frames, the load tick not counted
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF);
        check("req_drop_ff", int'(rng_req), 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        spawn_cnt = 0;
        for (int i = 0; i < 34; i++) tick_idle();
        check("no_spawn_before_35", spawn_cnt, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        check("spawn_at_35", int'(spawn), 1);

        // Speed saturation
        n = 0;
        while (inc_cnt < 300 && n < 3000) begin tick_idle(); n++; end
        check("inc_reach_300", inc_cnt, 300);
        check("speed_3", int'(speed), 3);
        n = 0;
        while (inc_cnt < 400 && n < 3000) begin tick_idle(); n++; end
        check("inc_reach_400", inc_cnt, 400);
        check("speed_sat", int'(speed), 3);

`ifdef DINO_PAUSE_EN
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        check("pause_enter", int'(state), 2);
        inc_cnt = 0; spawn_cnt = 0;
        for (int i = 0; i < 20; i++) tick_idle();
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        check("pause_hold_state", int'(state), 2);
        check("pause_no_inc", inc_cnt, 0);
        check("pause_speed", int'(speed), 3);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        check("pause_exit", int'(state), 1);
`else
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        check("pause_ignored", int'(state), 1);
`endif
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        check("over_at_end", int'(outs()), int'({2'b11, 1'b1, 2'd3, 4'b0000}));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
